// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with a small receive FIFO, sticky
// overrun / framing flags and a read-strobe pop.
// Optional build macro UART_RX_PARITY_EN: 8E1 frames with a PARITY state
// and a sticky o_Parity_Err output.
module uart_rx_buffered #(
  parameter int FIFO_AW     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_Clock,
  input  logic        i_Rst_L,
  input  logic [11:0] i_Clk_per_bit,
  input  logic        i_RX_Serial,
  input  logic        i_RD,
  input  logic        i_Clr_Err,
  output logic [7:0]  o_RX_Byte,
  output logic        o_RX_Valid,
  output logic        o_RX_Full,
  output logic        o_Overrun,
`ifdef UART_RX_PARITY_EN
  output logic        o_Parity_Err,
`endif
  output logic        o_Frame_Err
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev, fall;

  // Metastability chain; resets to idle-high so reset never fakes a start.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], i_RX_Serial};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Previous synced level for falling-edge (start bit) detection.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) rx_prev <= 1'b1;
    else          rx_prev <= rx_s;
  end

  assign fall = rx_prev & ~rx_s;

  // ---------------------------------------------------------------- fsm
  state_t      state, state_n;
  logic [11:0] cnt, cnt_n;
  logic [11:0] per, per_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, sh_n;
  logic        push, frame_set, par_set;
  logic [11:0] half_m1, per_m1;

  // per is clamped to >=4 when latched, so these never underflow.
  assign half_m1 = (per >> 1) - 12'd1;
  assign per_m1  = per - 12'd1;

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state   <= S_IDLE;
      cnt     <= '0;
      per     <= 12'd4;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      per     <= per_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
    end
  end

  // Next-state: half-period start check, then full-period samples.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 12'd1;
    per_n     = per;
    bit_n     = bit_idx;
    sh_n      = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (fall) begin
          state_n = S_START;
          per_n   = (i_Clk_per_bit < 12'd4) ? 12'd4 : i_Clk_per_bit;
        end
      end
      S_START: begin
        if (cnt == half_m1) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = S_DATA;
            bit_n   = '0;
          end else begin
            state_n = S_IDLE;  // glitch, silently dropped
          end
        end
      end
      S_DATA: begin
        if (cnt == per_m1) begin
          cnt_n = '0;
          sh_n  = {rx_s, shreg[7:1]};  // LSB arrives first
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
        if (cnt == per_m1) begin
          cnt_n   = '0;
          par_set = (rx_s != ^shreg);  // even parity
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == per_m1) begin
          cnt_n     = '0;
          state_n   = S_IDLE;
          push      = rx_s;
          frame_set = ~rx_s;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- fifo
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, wr_n, rd_n;
  logic             empty, full, do_pop, do_push, ovr_set;
  logic [7:0]       head_n;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  // Pop is evaluated first so a full FIFO can accept a same-cycle push.
  assign do_pop  = i_RD & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovr_set = push & full & ~do_pop;
  assign wr_n    = wr_ptr + {{FIFO_AW{1'b0}}, do_push};
  assign rd_n    = rd_ptr + {{FIFO_AW{1'b0}}, do_pop};

  // Head after this cycle's update: the incoming byte if it lands at the new
  // read slot (FIFO was empty), otherwise the stored entry.
  always_comb begin
    head_n = mem[rd_n[FIFO_AW-1:0]];
    if (do_push && (wr_ptr[FIFO_AW-1:0] == rd_n[FIFO_AW-1:0])) head_n = shreg;
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge i_Clock) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
  end

  // Pointers and registered FIFO status / head outputs.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_RX_Byte  <= 8'h00;
      o_RX_Valid <= 1'b0;
      o_RX_Full  <= 1'b0;
    end else begin
      wr_ptr     <= wr_n;
      rd_ptr     <= rd_n;
      o_RX_Byte  <= head_n;
      o_RX_Valid <= (wr_n != rd_n);
      o_RX_Full  <= (wr_n[FIFO_AW] != rd_n[FIFO_AW]) &&
                    (wr_n[FIFO_AW-1:0] == rd_n[FIFO_AW-1:0]);
    end
  end

  // Sticky error flags; a set event beats a same-cycle clear.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      o_Overrun   <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      o_Overrun   <= ovr_set   | (o_Overrun   & ~i_Clr_Err);
      o_Frame_Err <= frame_set | (o_Frame_Err & ~i_Clr_Err);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity flag; byte is still pushed if the stop bit is good.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) o_Parity_Err <= 1'b0;
    else          o_Parity_Err <= par_set | (o_Parity_Err & ~i_Clr_Err);
  end
`else
  logic unused_par;
  assign unused_par = par_set;
`endif

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: reception, FIFO fill/overrun,
// same-cycle push/pop, glitch rejection, framing error, clamp, reset.
module tb_uart_rx_buffered;

`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_l, rx, rd, clr;
  logic [11:0] cpb;
  logic [7:0]  rx_byte;
  logic        valid, full_o, ovr, ferr;
`ifdef UART_RX_PARITY_EN
  logic        perr;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  int lat;
  logic vld_d = 1'b0;

  uart_rx_buffered dut (
    .i_Clock      (clk),
    .i_Rst_L      (rst_l),
    .i_Clk_per_bit(cpb),
    .i_RX_Serial  (rx),
    .i_RD         (rd),
    .i_Clr_Err    (clr),
    .o_RX_Byte    (rx_byte),
    .o_RX_Valid   (valid),
    .o_RX_Full    (full_o),
    .o_Overrun    (ovr),
`ifdef UART_RX_PARITY_EN
    .o_Parity_Err (perr),
`endif
    .o_Frame_Err  (ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle at which o_RX_Valid rises.
  always @(negedge clk) begin
    if (valid && !vld_d) rise_cyc = cyc;
    vld_d = valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offset (in cycles from the start-bit drive) of the cycle whose closing
  // edge takes the stop sample: 2 sync flops + edge detect, half period,
  // then the remaining full periods.
  function automatic int push_at(input int p);
    return 2 + (p >> 1) + (NB - 1) * p;
  endfunction

  // Drive one frame with bit period p; optional rd / clr strobe at a given cycle.
  task automatic send_frame(input logic [7:0] b, input int p, input logic stop_bit,
                            input int rd_at, input int clr_at);
    logic [10:0] fr;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = b;
`ifdef UART_RX_PARITY_EN
    fr[9]  = ^b;
    fr[10] = stop_bit;
`else
    fr[9]  = stop_bit;
`endif
    for (int c = 0; c < NB * p; c++) begin
      rx  = fr[c / p];
      rd  = (c == rd_at);
      clr = (c == clr_at);
      tick(1);
    end
    rx = 1'b1; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1; tick(1);
    rd = 1'b0; tick(1);
  endtask

  task automatic clear_err();
    clr = 1'b1; tick(1);
    clr = 1'b0; tick(1);
  endtask

  logic [7:0] exp_q [4];

  initial begin
    rst_l = 1'b0; rx = 1'b1; rd = 1'b0; clr = 1'b0; cpb = 12'd16;
    tick(3);
    check("rst_valid", valid, 1'b0);
    check("rst_full",  full_o, 1'b0);
    check("rst_byte",  rx_byte, 8'h00);
    check("rst_ovr",   ovr, 1'b0);
    check("rst_ferr",  ferr, 1'b0);
    rst_l = 1'b1;
    tick(4);

    // 9600 Bd at 32 MHz, single byte with latency window
    cpb = 12'hD05;
    start_cyc = cyc;
    send_frame(8'hAF, 3333, 1'b1, -1, -1);
    tick(4);
    check("t1_valid", valid, 1'b1);
    check("t1_byte", rx_byte, 8'hAF);
    lat = rise_cyc - start_cyc;
    n_cmp++;
    assert (lat >= (19 * 3333) / 2 - 8 && lat <= (19 * 3333) / 2 + 8) else begin
      n_bad++;
      $error("FAIL t1_latency: observed %0d expected about %0d", lat, (19 * 3333) / 2);
    end
    pop();
    check("t1_pop_valid", valid, 1'b0);

    // Fill the FIFO
    cpb = 12'd16;
    send_frame(8'hCD, 16, 1'b1, -1, -1);
    send_frame(8'h54, 16, 1'b1, -1, -1);
    send_frame(8'hEB, 16, 1'b1, -1, -1);
    send_frame(8'h12, 16, 1'b1, -1, -1);
    tick(2);
    check("t2_full", full_o, 1'b1);
    check("t2_ovr", ovr, 1'b0);
    check("t2_head", rx_byte, 8'hCD);

    // Fifth byte while full is dropped
    send_frame(8'h99, 16, 1'b1, -1, -1);
    tick(2);
    check("t3_ovr", ovr, 1'b1);
    check("t3_full", full_o, 1'b1);
    check("t3_head", rx_byte, 8'hCD);
    clear_err();
    check("t3_clr", ovr, 1'b0);

    // Push with pop in the same cycle while full: accepted, no overrun
    send_frame(8'h77, 16, 1'b1, push_at(16), -1);
    tick(2);
    check("pp_ovr", ovr, 1'b0);
    check("pp_full", full_o, 1'b1);
    exp_q[0] = 8'h54; exp_q[1] = 8'hEB; exp_q[2] = 8'h12; exp_q[3] = 8'h77;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp_rd%0d", i), rx_byte, exp_q[i]);
      pop();
    end
    check("pp_empty", valid, 1'b0);
    check("pp_nfull", full_o, 1'b0);

    // Push with read strobe while empty: byte stored
    send_frame(8'h3E, 16, 1'b1, push_at(16), -1);
    tick(2);
    check("pe_valid", valid, 1'b1);
    check("pe_byte", rx_byte, 8'h3E);
    pop();

    // Read while empty is ignored
    pop();
    send_frame(8'hA5, 16, 1'b1, -1, -1);
    tick(2);
    check("re_byte", rx_byte, 8'hA5);
    pop();
    check("re_valid", valid, 1'b0);

    // Short low glitch on idle line
    rx = 1'b0; tick(5);
    rx = 1'b1; tick(40);
    check("gl_valid", valid, 1'b0);
    check("gl_ferr", ferr, 1'b0);
    check("gl_ovr", ovr, 1'b0);

    // Framing error leaves FIFO unchanged
    send_frame(8'h81, 16, 1'b1, -1, -1);
    send_frame(8'h42, 16, 1'b0, -1, -1);
    tick(2);
    check("fe_flag", ferr, 1'b1);
    check("fe_valid", valid, 1'b1);
    check("fe_head", rx_byte, 8'h81);
    clear_err();
    check("fe_clr", ferr, 1'b0);
    // Set wins over a same-cycle clear
    send_frame(8'h24, 16, 1'b0, -1, push_at(16));
    tick(2);
    check("fe_prio", ferr, 1'b1);
    pop();

    // Bit period below 4 is treated as 4
    cpb = 12'd2;
    send_frame(8'h3C, 4, 1'b1, -1, -1);
    tick(2);
    check("cl_valid", valid, 1'b1);
    check("cl_byte", rx_byte, 8'h3C);
    pop();
    cpb = 12'd16;

    // Reset mid-DATA with two bytes buffered
    send_frame(8'h11, 16, 1'b1, -1, -1);
    send_frame(8'h22, 16, 1'b1, -1, -1);
    rx = 1'b0; tick(16);
    rx = 1'b1; tick(16);
    rx = 1'b0; tick(8);
    rst_l = 1'b0; rx = 1'b1; tick(1);
    rst_l = 1'b1;
    check("mr_valid", valid, 1'b0);
    check("mr_full", full_o, 1'b0);
    check("mr_ferr", ferr, 1'b0);
    check("mr_ovr", ovr, 1'b0);
    check("mr_byte", rx_byte, 8'h00);
    tick(30);
    send_frame(8'h5A, 16, 1'b1, -1, -1);
    tick(2);
    check("mr_rx_valid", valid, 1'b1);
    check("mr_rx_byte", rx_byte, 8'h5A);
    pop();
    check("mr_empty", valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
